// File: rtl/key_evt_pkg.sv
// Shared definitions for key-handling blocks: FSM encodings and default cycle constants.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_WAIT2    = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_LONG     = 3'd4
    } key_state_e;

    // Default timings at a 50 MHz system clock.
    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEF_GAP_CYCLES    = 15_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

    // Largest of three cycle counts, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registers the debounced key level and flags press/release edges combinationally.
module key_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_c,
    output logic rel_c
);

    logic key_q;

    // Previous key level; reset to released so a key held low at reset release reads as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key_n;
        end
    end

    assign press_c = key_q & ~key_n;
    assign rel_c   = ~key_q & key_n;

endmodule

// File: rtl/key_event_classifier.sv
// Turns debounced key activity into click / double-click / long-press / repeat pulses.
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic deb_key_n,
    output logic key_held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             press_c;
    logic             rel_c;

    key_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .key_n   (deb_key_n),
        .press_c (press_c),
        .rel_c   (rel_c)
    );

    // Gesture FSM with a single shared counter; every pulse output is a one-cycle register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            key_held      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            key_held      <= ~deb_key_n;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (press_c) begin
                        state       <= ST_PRESS1;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    // Release wins over reaching the long-press threshold.
                    if (rel_c) begin
                        state         <= ST_WAIT2;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state      <= ST_LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT2: begin
                    // A second press on the expiry cycle still counts as a double click.
                    if (press_c) begin
                        state        <= ST_WAIT_REL;
                        cnt          <= '0;
                        press_pulse  <= 1'b1;
                        double_click <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        short_click <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_REL: begin
                    if (rel_c) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (rel_c) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor pops and compares.
module tb_key_event_classifier;

    localparam int unsigned LONG_C = 100;
    localparam int unsigned GAP_C  = 40;
    localparam int unsigned REP_C  = 20;

    // Pulse vector bit order: {repeat, long, double, short, release, press}
    localparam logic [5:0] P_PRESS = 6'b000001;
    localparam logic [5:0] P_REL   = 6'b000010;
    localparam logic [5:0] P_SHORT = 6'b000100;
    localparam logic [5:0] P_DBL   = 6'b001000;
    localparam logic [5:0] P_LONG  = 6'b010000;
    localparam logic [5:0] P_REP   = 6'b100000;

    typedef struct {
        int         cyc;
        logic [5:0] pulses;
    } exp_t;

    logic clk;
    logic rst;
    logic deb_key_n;
    logic key_held;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    key_event_classifier #(
        .LONG_CYCLES   (LONG_C),
        .GAP_CYCLES    (GAP_C),
        .REPEAT_CYCLES (REP_C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .deb_key_n     (deb_key_n),
        .key_held      (key_held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_click   (short_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: value seen at a negedge is the number of the posedge just before it.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with any pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t       e;
        obs = {repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse};
        if (obs != 6'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: at edge %0d got pulses=%b, required none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.pulses != obs) begin
                    n_bad++;
                    $display("FAIL pulse_event: got pulses=%b at edge %0d, required pulses=%b at edge %0d",
                             obs, cyc, e.pulses, e.cyc);
                end
            end
        end
    end

    task automatic expect_ev(input int c, input logic [5:0] p);
        exp_t e;
        e.cyc    = c;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns the posedge index that will sample the new level.
    task automatic set_key(input logic v, output int e);
        deb_key_n = v;
        e = cyc + 1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_quiet(input string name);
        logic [6:0] all;
        all = {key_held, repeat_pulse, long_press, double_click, short_click, release_pulse, press_pulse};
        n_cmp++;
        if (all !== 7'b0) begin
            n_bad++;
            $display("FAIL %s: outputs {held,rep,long,dbl,short,rel,press}=%b, required 0000000", name, all);
        end
    endtask

    initial begin
        int p, r, p2, r2;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        deb_key_n = 1'b1;
        wait_cyc(3);
        check_quiet("reset_state");
        rst = 1'b0;
        wait_cyc(5);

        // 1: short click, emitted GAP cycles after the release edge
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        wait_cyc(1);
        check_bit("key_held_pressed", key_held, 1'b1);
        wait_cyc(9);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        expect_ev(r + 40, P_SHORT);
        wait_cyc(1);
        check_bit("key_held_released", key_held, 1'b0);
        wait_cyc(59);

        // 2: double click, no short click
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        wait_cyc(10);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        wait_cyc(10);
        set_key(1'b0, p2);
        expect_ev(p2, P_PRESS | P_DBL);
        wait_cyc(10);
        set_key(1'b1, r2);
        expect_ev(r2, P_REL);
        wait_cyc(60);

        // 3: long hold with repeats, release before third repeat
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        expect_ev(p + 100, P_LONG);
        expect_ev(p + 120, P_REP);
        expect_ev(p + 140, P_REP);
        wait_cyc(150);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        wait_cyc(60);

        // 4: release sampled on the same edge the long threshold is reached
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        wait_cyc(100);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        expect_ev(r + 40, P_SHORT);
        wait_cyc(60);

        // 5: second press sampled on the gap-expiry edge
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        wait_cyc(10);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        wait_cyc(40);
        set_key(1'b0, p2);
        expect_ev(p2, P_PRESS | P_DBL);
        wait_cyc(10);
        set_key(1'b1, r2);
        expect_ev(r2, P_REL);
        wait_cyc(60);

        // 6: reset during LONG, key kept low becomes a fresh press
        set_key(1'b0, p);
        expect_ev(p, P_PRESS);
        expect_ev(p + 100, P_LONG);
        wait_cyc(105);
        rst = 1'b1;
        wait_cyc(1);
        check_quiet("reset_in_long");
        rst = 1'b0;
        expect_ev(cyc + 1, P_PRESS);
        wait_cyc(10);
        set_key(1'b1, r);
        expect_ev(r, P_REL);
        expect_ev(r + 40, P_SHORT);
        wait_cyc(60);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: %0d expected events never seen, first due at edge %0d, required 0 pending",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
